// File: rtl/dpi_exporter_group_buffer_if.sv
// Head-of-queue handshake for the exporter group buffer.
// The buffer drives the head entry; the exporter tick consumes it with ready.
interface dpi_exporter_group_buffer_if #(
    parameter int DATA_W  = 64,
    parameter int TRIG_W  = 2,
    parameter int STAMP_W = 32
);
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic [TRIG_W-1:0]  out_trig;
    logic [STAMP_W-1:0] out_stamp;

    // Buffer side: presents the head entry and observes the consumer's ready
    modport master (
        output out_valid,
        output out_data,
        output out_trig,
        output out_stamp,
        input  out_ready
    );

    // Consumer side: observes the head entry and accepts it with ready
    modport slave (
        input  out_valid,
        input  out_data,
        input  out_trig,
        input  out_stamp,
        output out_ready
    );
endinterface

// File: rtl/dpi_exporter_group_buffer.sv
// Front end for one exporter sensitive group.
// Samples the packed group whenever a trigger bit changes or is high,
// stamps the sample with a free-running cycle count and queues it in a
// show-ahead FIFO so the exporter tick can drain bursts without loss.
module dpi_exporter_group_buffer #(
    parameter int DATA_W  = 64,
    parameter int TRIG_W  = 2,
    parameter int DEPTH   = 8,
    parameter int STAMP_W = 32,
    parameter int OVF_W   = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      en,
    input  logic [TRIG_W-1:0]         trig,
    input  logic [DATA_W-1:0]         data,
    dpi_exporter_group_buffer_if.master head,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty,
    output logic [OVF_W-1:0]          overflow_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [OVF_W-1:0] OVF_MAX    = {OVF_W{1'b1}};

    logic [STAMP_W-1:0] stamp;
    logic [TRIG_W-1:0]  trig_last;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    logic [DATA_W-1:0]  mem_data  [DEPTH];
    logic [TRIG_W-1:0]  mem_trig  [DEPTH];
    logic [STAMP_W-1:0] mem_stamp [DEPTH];

    logic fire;
    logic pop;
    logic push_accepted;
    logic drop;

    // A trigger change (either direction) or any high trigger fires the group
    assign fire = en & ((|(trig ^ trig_last)) | (|trig));

    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);

    // A full FIFO can still take a sample when the head leaves in the same cycle
    assign pop           = ~empty & head.out_ready;
    assign push_accepted = fire & (~full | pop);
    assign drop          = fire & full & ~pop;

    // Show-ahead head; an empty FIFO presents zeros rather than stale entries
    assign head.out_valid = ~empty;
    assign head.out_data  = empty ? '0 : mem_data[rd_ptr];
    assign head.out_trig  = empty ? '0 : mem_trig[rd_ptr];
    assign head.out_stamp = empty ? '0 : mem_stamp[rd_ptr];

    // Free-running cycle stamp and trigger history, both independent of en
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stamp     <= '0;
            trig_last <= '0;
        end else begin
            stamp     <= stamp + STAMP_W'(1);
            trig_last <= trig;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_accepted) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_accepted, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Saturating count of samples lost to a full FIFO
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow_cnt <= '0;
        end else if (drop && (overflow_cnt != OVF_MAX)) begin
            overflow_cnt <= overflow_cnt + OVF_W'(1);
        end
    end

    // Entry storage; contents need no reset because empty masks the head
    always_ff @(posedge clock) begin
        if (push_accepted) begin
            mem_data[wr_ptr]  <= data;
            mem_trig[wr_ptr]  <= trig;
            mem_stamp[wr_ptr] <= stamp;
        end
    end

endmodule

// File: tb/tb_dpi_exporter_group_buffer.sv
// Scoreboard bench for the exporter group buffer: directed stimulus pushes
// hand-computed expected entries, a monitor pops and compares on each pop.
module tb_dpi_exporter_group_buffer;

    localparam int DATA_W  = 64;
    localparam int TRIG_W  = 2;
    localparam int DEPTH   = 8;
    localparam int STAMP_W = 32;
    localparam int OVF_W   = 16;

    typedef struct packed {
        logic [31:0] stamp;
        logic [1:0]  trig;
        logic [63:0] data;
    } entry_t;

    logic        clock;
    logic        reset;
    logic        en;
    logic [1:0]  trig;
    logic [63:0] data;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic [15:0] overflow_cnt;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;
    entry_t      exp_q[$];

    dpi_exporter_group_buffer_if #(
        .DATA_W (DATA_W),
        .TRIG_W (TRIG_W),
        .STAMP_W(STAMP_W)
    ) head_if ();

    dpi_exporter_group_buffer #(
        .DATA_W (DATA_W),
        .TRIG_W (TRIG_W),
        .DEPTH  (DEPTH),
        .STAMP_W(STAMP_W),
        .OVF_W  (OVF_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .en          (en),
        .trig        (trig),
        .data        (data),
        .head        (head_if),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .overflow_cnt(overflow_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [63:0] mk_data(input logic [31:0] s);
        return {s ^ 32'hDEADBEEF, 32'h5A000000 | s};
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic apply_stimulus(input logic e, input logic [1:0] t, input logic r);
        en               = e;
        trig             = t;
        head_if.out_ready = r;
        data             = mk_data(cyc);
    endtask

    task automatic expect_entry(input logic [31:0] s, input logic [1:0] t);
        entry_t ent;
        ent.stamp = s;
        ent.trig  = t;
        ent.data  = mk_data(s);
        exp_q.push_back(ent);
    endtask

    // Monitor: every accepted head is compared against the oldest expectation
    initial begin
        forever begin
            entry_t got;
            @(negedge clock);
            if (reset && head_if.out_valid && head_if.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_pop actual=%0h expected=none",
                             head_if.out_stamp);
                end else begin
                    got = exp_q.pop_front();
                    check_output("head_stamp", head_if.out_stamp, got.stamp);
                    check_output("head_trig",  head_if.out_trig,  got.trig);
                    check_output("head_data",  head_if.out_data,  got.data);
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #50000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset             = 1'b0;
        en                = 1'b1;
        trig              = 2'b00;
        data              = '0;
        head_if.out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;

        // State while held in reset
        check_output("rst_empty",     empty, 1);
        check_output("rst_valid",     head_if.out_valid, 0);
        check_output("rst_full",      full, 0);
        check_output("rst_count",     count, 0);
        check_output("rst_ovf",       overflow_cnt, 0);
        check_output("rst_out_data",  head_if.out_data, 0);
        check_output("rst_out_stamp", head_if.out_stamp, 0);
        check_output("rst_out_trig",  head_if.out_trig, 0);

        reset = 1'b1;
        cyc   = 0;

        // Idle stamps 0..4: nothing fires
        repeat (5) begin
            apply_stimulus(1, 2'b00, 0);
            tick();
        end
        check_output("idle_count", count, 0);
        check_output("idle_empty", empty, 1);

        // Rising edge at stamp 5, held through 7, falling edge at 8
        apply_stimulus(1, 2'b01, 0); expect_entry(5, 2'b01); tick();
        check_output("latency_valid", head_if.out_valid, 1);
        check_output("latency_stamp", head_if.out_stamp, 5);
        apply_stimulus(1, 2'b01, 0); expect_entry(6, 2'b01); tick();
        apply_stimulus(1, 2'b01, 0); expect_entry(7, 2'b01); tick();
        apply_stimulus(1, 2'b00, 0); expect_entry(8, 2'b00); tick();
        apply_stimulus(1, 2'b00, 0); tick();
        check_output("edge_count", count, 4);
        check_output("hold_stamp", head_if.out_stamp, 5);

        // Drain stamps 5..8 on consecutive cycles
        apply_stimulus(1, 2'b00, 1);
        repeat (4) tick();
        check_output("drain_valid", head_if.out_valid, 0);
        check_output("drain_empty", empty, 1);
        check_output("drain_queue", exp_q.size(), 0);

        // Overflow: 12 fires from stamp 14, first 8 accepted
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(1, 2'b01, 0);
            if (i < 8) expect_entry(cyc, 2'b01);
            tick();
            if (i == 7) begin
                check_output("ovf_full_at_8", full, 1);
                check_output("ovf_count_at_8", count, 8);
            end
        end
        check_output("ovf_cnt", overflow_cnt, 4);
        check_output("ovf_head", head_if.out_stamp, 14);

        // Full with same-cycle pop: stamp 26 enters at the tail
        apply_stimulus(1, 2'b01, 1); expect_entry(26, 2'b01); tick();
        check_output("pushpop_count", count, 8);
        check_output("pushpop_ovf",   overflow_cnt, 4);

        // Disabled with trigger toggling: pops only
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(0, (i % 2 == 1) ? 2'b10 : 2'b01, 1);
            tick();
        end
        check_output("dis_empty", empty, 1);
        check_output("dis_count", count, 0);
        check_output("dis_ovf",   overflow_cnt, 4);
        check_output("dis_queue", exp_q.size(), 0);

        // Re-enable with steady low trigger: no fire
        apply_stimulus(0, 2'b00, 0); tick();
        apply_stimulus(1, 2'b00, 0); tick();
        tick();
        check_output("reen_count", count, 0);

        // Burst of 5, then asynchronous reset mid-burst
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1, 2'b10, 0);
            expect_entry(cyc, 2'b10);
            tick();
        end
        check_output("burst_count", count, 5);
        reset = 1'b0;
        exp_q.delete();
        #1;
        check_output("async_count", count, 0);
        check_output("async_valid", head_if.out_valid, 0);
        check_output("async_empty", empty, 1);
        check_output("async_ovf",   overflow_cnt, 0);

        @(posedge clock);
        #1;
        reset = 1'b1;
        cyc   = 0;
        apply_stimulus(1, 2'b10, 0); expect_entry(0, 2'b10); tick();
        check_output("post_rst_valid", head_if.out_valid, 1);
        check_output("post_rst_stamp", head_if.out_stamp, 0);
        check_output("post_rst_trig",  head_if.out_trig, 2'b10);
        apply_stimulus(0, 2'b10, 1); tick();
        check_output("final_empty", empty, 1);
        check_output("final_queue", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
